gcd_dispatcher: RTL
===================

Name: gcd_dispatcher

Overview:
- Upstream feeder for GCD_Calculator.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues each pair to the calculator with a one-cycle go pulse, captures the result on done, and presents it on a valid/ready result stream with a status code.
- Shields the calculator from zero operands (non-terminating in the subtractive core) and from hangs (cycle timeout).

Parameters:
- WIDTH, 8, operand/result width; must match GCD_Calculator WIDTH.
- DEPTH, 4, input FIFO entries; power of 2, >= 2.
- TIMEOUT_CYCLES, 1024, max cycles in WAIT before aborting a job.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset; same net drives GCD_Calculator rst.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full.
- in_x  in  WIDTH  operand x.
- in_y  in  WIDTH  operand y.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_gcd  out  WIDTH  result.
- out_status  out  2  00 ok, 01 zero-operand bypass, 10 timeout.
- gcd_go  out  1  one-cycle start pulse to calculator.
- gcd_x  out  WIDTH  operand x to calculator.
- gcd_y  out  WIDTH  operand y to calculator.
- gcd_done  in  1  calculator done; held high until next go.
- gcd_out  in  WIDTH  calculator result; valid while gcd_done high.

Behaviour:
- Reset (async assert, sync release):
  - FIFO is emptied and the state is IDLE.
  - in_ready=0 while rst is high, 1 on the first cycle after release.
  - out_valid, out_gcd, out_status, gcd_go, gcd_x, gcd_y are all 0.
  - Reset mid-job abandons the job, the FIFO contents, and any held result.
- FIFO:
  - Push on in_valid&&in_ready; in_ready = !full.
  - No push-through when full: a same-cycle pop does not raise in_ready that cycle.
  - Pointers wrap mod DEPTH; the count is DEPTH+1 states wide.
  - in_valid while !in_ready is ignored; the data is not captured.
- FSM states: IDLE, ISSUE, SETTLE, WAIT, HOLD.
- IDLE:
  - If the FIFO is non-empty, pop the head into gcd_x/gcd_y registers.
  - If x==0 or y==0: go to HOLD, out_gcd = x|y, out_status=01. gcd(0,0)=0.
  - Otherwise go to ISSUE.
- ISSUE:
  - gcd_go=1 for exactly this one cycle; gcd_x/gcd_y are stable from ISSUE through WAIT.
  - Go to SETTLE.
- SETTLE:
  - One cycle in which gcd_done is ignored; a stale done from the prior job falls here.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On gcd_done=1: out_gcd=gcd_out, out_status=00, go to HOLD.
  - Else, when the counter reaches TIMEOUT_CYCLES-1: out_gcd=0, out_status=10, go to HOLD.
  - If done and timeout occur in the same cycle, done wins.
- HOLD:
  - out_valid=1; out_gcd and out_status are stable until out_valid&&out_ready.
  - Then return to IDLE.
  - The next pop happens in the IDLE cycle after acceptance, so there are 2 cycles minimum between results.
- gcd_go is never asserted outside ISSUE; at most one job is in flight.
- Latency:
  - Pair pushed at edge N into an empty FIFO with the FSM in IDLE: popped at edge N+1, gcd_go high in cycle N+1..N+2.
  - out_valid rises on the edge after gcd_done is sampled in WAIT.
  - Zero-bypass: out_valid high after edge N+1.
- Pushes may continue during any state until the FIFO is full.

Test Plan:
- Reset, push (12,18), out_ready=1 -> exactly one gcd_go pulse; out_gcd=6, status=00; out_valid for 1 cycle.
- Push (0,9), (0,0), (7,0) -> no gcd_go; results 9, 0, 7, each status=01, in order.
- Hold out_ready=0, push 6 pairs back-to-back with DEPTH=4:
  - in_ready drops after pairs 1+4 (one popped and in flight); stall pairs are not lost.
  - Release out_ready -> all results emitted in push order: (15,5)->5, (9,6)->3, (14,21)->7, (8,8)->8, (13,7)->1, (255,85)->85.
- Model calculator never raising done, TIMEOUT_CYCLES=16 -> out_status=10 and out_gcd=0 exactly 16 cycles after SETTLE.
  - The next queued pair still completes with status=00.
- Assert rst while in WAIT with 3 pairs queued:
  - All outputs go to 0 immediately and no result is emitted.
  - After release, push (21,14) -> 7.
- Sweep: all i,j in 1..15 pushed via the stream and checked against a reference gcd.
  - Assertions over the sweep: gcd_go |=> !gcd_go; out_valid&&!out_ready |=> $stable(out_gcd).

Source files
------------

// File: rtl/gcd_dispatcher.sv
// gcd_dispatcher: upstream feeder for a GCD_Calculator core.
//
// Operand pairs arrive on a valid/ready stream and are buffered in a small
// FIFO. Each pair is handed to the calculator with a one-cycle go pulse, the
// result is captured on done and offered on a valid/ready result stream with
// a status code. Zero operands never reach the calculator (they would not
// terminate in a subtractive core) and a cycle timeout aborts a hung job.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand stream handshake; in_ready = FIFO not full
//   in_x, in_y          operand pair
//   out_valid/out_ready result stream handshake
//   out_gcd             result value
//   out_status          00 ok, 01 zero-operand bypass, 10 timeout
//   gcd_go              one-cycle start pulse to the calculator
//   gcd_x, gcd_y        operands to the calculator, stable ISSUE..WAIT
//   gcd_done, gcd_out   calculator completion flag (held) and result

module gcd_dispatcher #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [1:0]       out_status,
  output logic             gcd_go,
  output logic [WIDTH-1:0] gcd_x,
  output logic [WIDTH-1:0] gcd_y,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BYPASS  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t state;

  logic [WIDTH-1:0] mem_x [DEPTH];
  logic [WIDTH-1:0] mem_y [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [TW-1:0]    tcnt;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_x;
  logic [WIDTH-1:0] head_y;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  // in_ready depends only on occupancy, so a pop in the same cycle as a full
  // FIFO never lets a push through.
  assign in_ready = !rst && !full;
  assign push   = in_valid && in_ready;
  assign pop    = (state == S_IDLE) && !empty;
  assign head_x = mem_x[rd_ptr];
  assign head_y = mem_y[rd_ptr];

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr] <= in_x;
      mem_y[wr_ptr] <= in_y;
    end
  end

  // FIFO control: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Job FSM with registered outputs. gcd_go is registered on the transition
  // into ISSUE, so it is high for exactly the ISSUE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      gcd_go     <= 1'b0;
      gcd_x      <= '0;
      gcd_y      <= '0;
      out_valid  <= 1'b0;
      out_gcd    <= '0;
      out_status <= ST_OK;
      tcnt       <= '0;
    end else begin
      gcd_go <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            gcd_x <= head_x;
            gcd_y <= head_y;
            if (head_x == '0 || head_y == '0) begin
              // gcd(a,0) = a and gcd(0,0) = 0, both equal to x|y.
              out_gcd    <= head_x | head_y;
              out_status <= ST_BYPASS;
              out_valid  <= 1'b1;
              state      <= S_HOLD;
            end else begin
              gcd_go <= 1'b1;
              state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          // done may still be high from the previous job here; ignore it.
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (gcd_done) begin
            out_gcd    <= gcd_out;
            out_status <= ST_OK;
            out_valid  <= 1'b1;
            state      <= S_HOLD;
          end else if (tcnt == T_LAST) begin
            out_gcd    <= '0;
            out_status <= ST_TIMEOUT;
            out_valid  <= 1'b1;
            state      <= S_HOLD;
          end else begin
            tcnt <= tcnt + T_ONE;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
